// File: rtl/dmem_stall_pkg.sv
// Shared types and limits for the data-memory stall controller.
// Holds the FSM encoding, counter widths, legal parameter ranges and the latency selector.
package dmem_stall_pkg;

  localparam int unsigned LAT_W       = 8;
  localparam int unsigned LAT_MIN     = 1;
  localparam int unsigned LAT_MAX     = 255;
  localparam int unsigned TIMEOUT_MIN = 1;
  localparam int unsigned TIMEOUT_MAX = 255;

  typedef logic [LAT_W-1:0] lat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } stall_state_e;

  typedef struct packed {
    logic stall;
    logic done;
    logic err;
  } stall_rsp_t;

  // A store wins over a load when both are flagged in the same instruction.
  function automatic lat_t sel_lat(input logic mem_write, input lat_t rd_lat, input lat_t wr_lat);
    return mem_write ? wr_lat : rd_lat;
  endfunction

endpackage

// File: rtl/dmem_stall_ctrl_sat_counter.sv
// Saturating up-counter; increments while inc is high and sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  if (WIDTH < 1) begin : g_bad_width
    $error("sat_counter WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage stall controller: freezes the pipeline for a fixed load/store latency,
// optionally waits on mem_ready with a bounded HOLD, and counts stalled cycles.
module dmem_stall_ctrl
  import dmem_stall_pkg::*;
#(
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned WRITE_LAT = 1,
  parameter int unsigned USE_READY = 0,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             mem_ready,
  input  logic             flush,
  output logic             MemStall,
  output logic             mem_done,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  if ((READ_LAT < LAT_MIN) || (READ_LAT > LAT_MAX)) begin : g_bad_read_lat
    $error("READ_LAT out of range 1..255");
  end
  if ((WRITE_LAT < LAT_MIN) || (WRITE_LAT > LAT_MAX)) begin : g_bad_write_lat
    $error("WRITE_LAT out of range 1..255");
  end
  if ((TIMEOUT < TIMEOUT_MIN) || (TIMEOUT > TIMEOUT_MAX)) begin : g_bad_timeout
    $error("TIMEOUT out of range 1..255");
  end
  if (USE_READY > 1) begin : g_bad_use_ready
    $error("USE_READY must be 0 or 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  localparam lat_t RD_LAT   = LAT_W'(READ_LAT);
  localparam lat_t WR_LAT   = LAT_W'(WRITE_LAT);
  localparam lat_t TO_LIMIT = LAT_W'(TIMEOUT);
  localparam logic READY_EN = (USE_READY != 0);

  stall_state_e state_q, state_d;
  lat_t         cnt_q, cnt_d;
  lat_t         tcnt_q, tcnt_d;
  stall_rsp_t   rsp_c;
  logic         is_mem;

  assign is_mem = MemRead | MemWrite;

  // Next-state and release decision; flush overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    rsp_c   = '0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem && !flush) begin
          rsp_c.stall = 1'b1;
          cnt_d       = sel_lat(MemWrite, RD_LAT, WR_LAT) - LAT_W'(1);
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          rsp_c.stall = 1'b1;
          cnt_d       = cnt_q - LAT_W'(1);
        end else if (!READY_EN || mem_ready) begin
          rsp_c.done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          rsp_c.stall = 1'b1;
          tcnt_d      = LAT_W'(1);
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (flush) begin
          tcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          rsp_c.done = 1'b1;
          tcnt_d     = '0;
          state_d    = ST_IDLE;
        end else if (tcnt_q == TO_LIMIT) begin
          rsp_c.err = 1'b1;
          tcnt_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          rsp_c.stall = 1'b1;
          tcnt_d      = tcnt_q + LAT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        tcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Outputs act in the same cycle as the request, so they are gated by reset directly.
  assign MemStall = rsp_c.stall & ~reset;
  assign mem_done = rsp_c.done  & ~reset;
  assign mem_err  = rsp_c.err   & ~reset;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (MemStall),
    .count (stall_count)
  );

  a_done_err_excl : assert property (@(posedge clk) disable iff (reset) !(mem_done && mem_err));

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Bench for dmem_stall_ctrl: four configurations share one stimulus stream and are
// checked every cycle against an elapsed-time model, plus literal scenario checks.
module tb_dmem_stall_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_read = 1'b0;
  logic mem_write = 1'b0;
  logic mem_ready = 1'b0;
  logic flush = 1'b0;

  logic [3:0] stall_v;
  logic [3:0] done_v;
  logic [3:0] err_v;
  logic [31:0] cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;
  logic [31:0] cnt_a [4];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // u0: defaults, u1: RL4/WL3, u2: ready-wait RL2 TO4, u3: defaults with 2-bit count
  dmem_stall_ctrl #(.READ_LAT(1), .WRITE_LAT(1), .USE_READY(0), .TIMEOUT(16), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write), .mem_ready(mem_ready),
    .flush(flush), .MemStall(stall_v[0]), .mem_done(done_v[0]), .mem_err(err_v[0]), .stall_count(cnt0));
  dmem_stall_ctrl #(.READ_LAT(4), .WRITE_LAT(3), .USE_READY(0), .TIMEOUT(16), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write), .mem_ready(mem_ready),
    .flush(flush), .MemStall(stall_v[1]), .mem_done(done_v[1]), .mem_err(err_v[1]), .stall_count(cnt1));
  dmem_stall_ctrl #(.READ_LAT(2), .WRITE_LAT(1), .USE_READY(1), .TIMEOUT(4), .CNT_W(32)) u2 (
    .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write), .mem_ready(mem_ready),
    .flush(flush), .MemStall(stall_v[2]), .mem_done(done_v[2]), .mem_err(err_v[2]), .stall_count(cnt2));
  dmem_stall_ctrl #(.READ_LAT(1), .WRITE_LAT(1), .USE_READY(0), .TIMEOUT(16), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write), .mem_ready(mem_ready),
    .flush(flush), .MemStall(stall_v[3]), .mem_done(done_v[3]), .mem_err(err_v[3]), .stall_count(cnt3));

  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = cnt2;
  assign cnt_a[3] = 32'(cnt3);

  // Model configuration, mirroring the instance parameters above.
  int unsigned m_rl [4] = '{1, 4, 2, 1};
  int unsigned m_wl [4] = '{1, 3, 1, 1};
  int unsigned m_ur [4] = '{0, 0, 1, 0};
  int unsigned m_to [4] = '{16, 16, 4, 16};
  int unsigned m_w  [4] = '{32, 32, 32, 2};

  // Model state: an access is "busy" after its start cycle; e = cycles since start.
  bit          m_busy [4];
  int unsigned m_lat  [4];
  int unsigned m_e    [4];
  longint unsigned m_cnt [4];
  logic e_stall [4];
  logic e_done  [4];
  logic e_err   [4];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 1'b0;
      m_lat[i]  = 0;
      m_e[i]    = 0;
      m_cnt[i]  = 0;
    end
  end

  // Per-cycle comparison against the model, then advance the model past the next edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 4; i++) begin
      e_stall[i] = 1'b0;
      e_done[i]  = 1'b0;
      e_err[i]   = 1'b0;
      if (reset) begin
        m_busy[i] = 1'b0;
        m_cnt[i]  = 0;
      end else if (!m_busy[i]) begin
        e_stall[i] = (mem_read | mem_write) & ~flush;
      end else if (flush) begin
        e_stall[i] = 1'b0;
      end else if (m_e[i] < m_lat[i]) begin
        e_stall[i] = 1'b1;
      end else if (m_ur[i] == 0 || mem_ready) begin
        e_done[i] = 1'b1;
      end else if (m_e[i] - m_lat[i] == m_to[i]) begin
        e_err[i] = 1'b1;
      end else begin
        e_stall[i] = 1'b1;
      end

      chk($sformatf("model_u%0d_stall", i), longint'(stall_v[i]), longint'(e_stall[i]));
      chk($sformatf("model_u%0d_done", i), longint'(done_v[i]), longint'(e_done[i]));
      chk($sformatf("model_u%0d_err", i), longint'(err_v[i]), longint'(e_err[i]));
      chk($sformatf("model_u%0d_count", i), longint'(cnt_a[i]), m_cnt[i]);

      if (!reset) begin
        if (e_stall[i] && m_cnt[i] < ((64'd1 << m_w[i]) - 64'd1)) m_cnt[i] = m_cnt[i] + 1;
        if (!m_busy[i]) begin
          if (e_stall[i]) begin
            m_busy[i] = 1'b1;
            m_e[i]    = 1;
            m_lat[i]  = mem_write ? m_wl[i] : m_rl[i];
          end
        end else if (e_stall[i]) begin
          m_e[i] = m_e[i] + 1;
        end else begin
          m_busy[i] = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic rd, input logic wr, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    reset = rst; mem_read = rd; mem_write = wr; mem_ready = rdy; flush = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state, including a request presented while reset is high.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall_all", longint'(stall_v), 0);
    chk("rst_count_u0", longint'(cnt0), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_req_stall_all", longint'(stall_v), 0);
    chk("rst_req_done_all", longint'(done_v), 0);
    idle(2);

    // Default latency load: 1 stall then release.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1_c1_stall_u0", longint'(stall_v[0]), 1);
    chk("s1_c1_done_u0", longint'(done_v[0]), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1_c2_stall_u0", longint'(stall_v[0]), 0);
    chk("s1_c2_done_u0", longint'(done_v[0]), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1_count_u0", longint'(cnt0), 1);
    idle(12);

    // Store with WRITE_LAT=3: 1,1,1,0 and done on the 4th cycle (u1 counted 4 earlier).
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("s2_c%0d_stall_u1", k + 1), longint'(stall_v[1]), (k < 3) ? 1 : 0);
      chk($sformatf("s2_c%0d_done_u1", k + 1), longint'(done_v[1]), (k == 3) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s2_count_u1", longint'(cnt1), 7);
    idle(12);

    // Ready-wait: stall through latency and HOLD until mem_ready.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s3_c1_stall_u2", longint'(stall_v[2]), 1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("s3_c%0d_stall_u2", k + 2), longint'(stall_v[2]), 1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s3_c6_stall_u2", longint'(stall_v[2]), 0);
    chk("s3_c6_done_u2", longint'(done_v[2]), 1);
    chk("s3_c6_err_u2", longint'(err_v[2]), 0);
    idle(12);

    // Timeout: mem_ready never comes, release with error on the 4th HOLD cycle.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("s4_c%0d_stall_u2", k + 2), longint'(stall_v[2]), 1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s4_c7_stall_u2", longint'(stall_v[2]), 0);
    chk("s4_c7_err_u2", longint'(err_v[2]), 1);
    chk("s4_c7_done_u2", longint'(done_v[2]), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s4_c8_err_u2", longint'(err_v[2]), 0);
    idle(12);

    // Flush in the 2nd WAIT cycle of a 4-cycle load.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s5_c1_stall_u1", longint'(stall_v[1]), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_c2_stall_u1", longint'(stall_v[1]), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s5_flush_stall_u1", longint'(stall_v[1]), 0);
    chk("s5_flush_done_u1", longint'(done_v[1]), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_after_done_u1", longint'(done_v[1]), 0);
    idle(12);

    // Reset mid-WAIT abandons the access immediately.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_rst_stall_all", longint'(stall_v), 0);
    chk("s5_rst_done_all", longint'(done_v), 0);
    chk("s5_rst_count_u1", longint'(cnt1), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_post_rst_stall_u1", longint'(stall_v[1]), 0);
    idle(6);

    // Back-to-back LAT=1 loads; 2-bit counter saturates at 3.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("s6_c%0d_stall_u0", k + 1), longint'(stall_v[0]), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("s6_c%0d_done_u0", k + 1), longint'(done_v[0]), (k % 2 == 1) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_count_u0", longint'(cnt0), 4);
    chk("s6_count_u3_sat", longint'(cnt3), 3);
    idle(12);

    // Load+store together uses WRITE_LAT; flush blocks a start from IDLE.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s7_c1_stall_u1", longint'(stall_v[1]), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s7_c3_stall_u1", longint'(stall_v[1]), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s7_c4_done_u1", longint'(done_v[1]), 1);
    idle(12);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("s7_idle_flush_stall_all", longint'(stall_v), 0);
    idle(2);

    // Mixed traffic checked by the model alone.
    for (int k = 0; k < 120; k++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_stall_ctrl.md
DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, meaning stall cycles for a load (legal range 1..255).
REQ-002 SHALL have parameter WRITE_LAT, default 1, meaning stall cycles for a store (legal range 1..255).
REQ-003 SHALL have parameter USE_READY, default 0, meaning 1 = also wait for mem_ready after the latency count.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning maximum HOLD cycles before forced release with error (legal range 1..255).
REQ-005 SHALL have parameter CNT_W, default 32, meaning stall_count width.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 MemRead  in  1  MEM-stage instruction is a load.
REQ-009 MemWrite  in  1  MEM-stage instruction is a store.
REQ-010 mem_ready  in  1  data memory completion; ignored when USE_READY=0.
REQ-011 flush  in  1  synchronous abort of the MEM-stage access.
REQ-012 MemStall  out  1  freeze PC and pipeline registers upstream of and including MEM/WB.
REQ-013 mem_done  out  1  one-cycle pulse in the release cycle of a completed access.
REQ-014 mem_err  out  1  one-cycle pulse when an access is released by timeout.
REQ-015 stall_count  out  CNT_W  saturating count of cycles with MemStall=1.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and HOLD; isMem = MemRead | MemWrite.
REQ-017 In IDLE with isMem=1 and flush=0: MemStall=1 combinationally in the same cycle; cnt <= LAT-1; next state is WAIT.
REQ-018 LAT SHALL be WRITE_LAT if MemWrite=1 (including when both are set); otherwise READ_LAT.
REQ-019 In IDLE with isMem=0 or flush=1: MemStall=0 and state stays IDLE.
REQ-020 In WAIT with cnt!=0: MemStall=1 and cnt decrements by 1.
REQ-021 In WAIT with cnt==0: if USE_READY=0 or mem_ready=1, MemStall=0, mem_done=1 and next state is IDLE (release cycle).
REQ-022 In WAIT with cnt==0, USE_READY=1 and mem_ready=0: MemStall=1; tcnt <= 1; next state is HOLD.
REQ-023 In HOLD with mem_ready=1: MemStall=0, mem_done=1, next state IDLE.
REQ-024 In HOLD with mem_ready=0 and tcnt==TIMEOUT: MemStall=0, mem_err=1, mem_done=0, next state IDLE.
REQ-025 In HOLD otherwise: MemStall=1 and tcnt increments by 1.
REQ-026 Stall duration SHALL be exactly LAT cycles (USE_READY=0), followed by exactly one release cycle; LAT=1 yields 1 stall cycle then release.
REQ-027 flush=1 in WAIT or HOLD SHALL force MemStall=0, mem_done=0, mem_err=0 that cycle and next state IDLE; flush has priority over all other inputs.
REQ-028 After a release cycle, a new access SHALL be accepted from IDLE on the next cycle, with back-to-back accesses and no extra bubble.
REQ-029 Changes on MemRead, MemWrite or LAT selection during WAIT/HOLD SHALL be ignored.
REQ-030 stall_count SHALL increment on every cycle with MemStall=1 and hold at all-ones without wrapping.
REQ-031 mem_done and mem_err SHALL never be asserted in the same cycle.

Reset
REQ-032 reset=1 SHALL immediately force state=IDLE, cnt=0, tcnt=0 and stall_count=0; while reset is high, MemStall, mem_done and mem_err SHALL be 0.
REQ-033 Reset asserted mid-access SHALL abandon the access; no mem_done or mem_err SHALL follow.

Structure
REQ-034 State encodings and the legal latency/timeout limits SHALL live in a shared package dmem_stall_pkg.
REQ-035 The saturating stall_count SHALL be a sub-module sat_counter, parametrised by width.
REQ-036 Latency and timeout counters SHALL be 8 bits wide; out-of-range parameters SHALL be rejected at elaboration.

Verification
REQ-037 Defaults; MemRead=1 for 2 cycles -> MemStall 1,0; mem_done at cycle 2; stall_count=1.
REQ-038 WRITE_LAT=3; MemWrite held -> MemStall 1,1,1,0; mem_done on the 4th cycle; stall_count=3.
REQ-039 USE_READY=1, READ_LAT=2; mem_ready rises 3 cycles late -> MemStall stays high until mem_ready, then mem_done=1.
REQ-040 USE_READY=1, TIMEOUT=4; mem_ready=0 forever -> mem_err pulse after 4 HOLD cycles, MemStall=0, state IDLE.
REQ-041 READ_LAT=4; flush in the 2nd WAIT cycle -> MemStall=0 that cycle, no mem_done; reset mid-WAIT -> all outputs 0 immediately.
REQ-042 Back-to-back loads with LAT=1 -> MemStall pattern 1,0,1,0; CNT_W=2 -> stall_count saturates at 3.
